// File: rtl/leb128_decoder_pkg.sv
// Shared constants and types for the LEB128 immediate decoder.
package leb128_decoder_pkg;

  // Decoder control states.
  typedef enum logic [1:0] {
    StAccum = 2'd0,
    StDone  = 2'd1,
    StError = 2'd2
  } leb_state_e;

  // Trap codes shared with the CPU core.
  localparam logic [3:0] TrapNone   = 4'd0;
  localparam logic [3:0] TrapDecode = 4'd2;

  // Maximum encoded lengths in bytes.
  localparam logic [3:0] MaxLen32 = 4'd5;
  localparam logic [3:0] MaxLen64 = 4'd10;

endpackage

// File: rtl/leb128_decoder.sv
// LEB128 immediate decoder: accumulates 7-bit groups from the fetch stream,
// sign/zero-extends the result to 64 bits and traps on malformed encodings.
module leb128_decoder
  import leb128_decoder_pkg::*;
#(
  parameter logic [3:0] TRAP_CODE = TrapDecode
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        is_signed,
  input  logic        is_64,
  output logic [63:0] value,
  output logic        value_valid,
  input  logic        value_ready,
  output logic [3:0]  bytes_used,
  output logic [3:0]  trap,
  input  logic        trap_clear
);

  leb_state_e  state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] value_q, value_d;
  logic [3:0]  bytes_used_q, bytes_used_d;
  logic [3:0]  trap_q, trap_d;
  logic        signed_q, signed_d;
  logic        w64_q, w64_d;

  // Checks the payload bits of a maximum-length byte against the target width.
  function automatic logic final_ok(input logic [7:0] b, input logic sgn, input logic w64);
    logic ok;
    if (w64) begin
      ok = sgn ? ((b[6:0] == 7'h00) || (b[6:0] == 7'h7f)) : (b[6:1] == 6'h00);
    end else begin
      ok = sgn ? ((b[6:3] == 4'h0) || (b[6:3] == 4'hf)) : (b[6:4] == 3'h0);
    end
    return ok;
  endfunction

  logic        xfer;
  logic        cur_signed, cur_w64;
  logic        last_byte;
  logic [6:0]  shamt;
  logic [6:0]  fill_sh;
  logic [63:0] merged;
  logic [63:0] filled;

  // Next-state, datapath and output decode.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    acc_d        = acc_q;
    value_d      = value_q;
    bytes_used_d = bytes_used_q;
    trap_d       = trap_q;
    signed_d     = signed_q;
    w64_d        = w64_q;

    byte_ready  = (state_q == StAccum);
    value_valid = (state_q == StDone);
    xfer        = byte_valid && byte_ready;

    // Mode bits come from the inputs only on the first byte of a value.
    cur_signed = (k_q == 4'd0) ? is_signed : signed_q;
    cur_w64    = (k_q == 4'd0) ? is_64 : w64_q;
    last_byte  = (k_q == ((cur_w64 ? MaxLen64 : MaxLen32) - 4'd1));

    shamt   = 7'(7 * k_q);
    fill_sh = 7'(7 * (k_q + 4'd1));
    merged  = acc_q | (64'(byte_in[6:0]) << shamt);
    // A shift of 64 or more yields 0, so the mask becomes empty for a full 10-byte value.
    filled  = merged;
    if (cur_signed && byte_in[6]) begin
      filled = merged | ~((64'd1 << fill_sh) - 64'd1);
    end
    if (!cur_w64) begin
      filled = cur_signed ? {{32{filled[31]}}, filled[31:0]} : {32'h0, filled[31:0]};
    end

    unique case (state_q)
      StAccum: begin
        if (xfer) begin
          signed_d = cur_signed;
          w64_d    = cur_w64;
          if (last_byte && (byte_in[7] || !final_ok(byte_in, cur_signed, cur_w64))) begin
            state_d = StError;
            trap_d  = TRAP_CODE;
          end else if (!byte_in[7]) begin
            state_d      = StDone;
            value_d      = filled;
            bytes_used_d = k_q + 4'd1;
            acc_d        = merged;
          end else begin
            acc_d = merged;
            k_d   = k_q + 4'd1;
          end
        end
      end
      StDone: begin
        if (value_ready) begin
          state_d = StAccum;
          k_d     = 4'd0;
          acc_d   = 64'h0;
        end
      end
      StError: begin
        if (trap_clear) begin
          state_d = StAccum;
          trap_d  = TrapNone;
          k_d     = 4'd0;
          acc_d   = 64'h0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StAccum;
      k_q          <= 4'd0;
      acc_q        <= 64'h0;
      value_q      <= 64'h0;
      bytes_used_q <= 4'd0;
      trap_q       <= TrapNone;
      signed_q     <= 1'b0;
      w64_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      value_q      <= value_d;
      bytes_used_q <= bytes_used_d;
      trap_q       <= trap_d;
      signed_q     <= signed_d;
      w64_q        <= w64_d;
    end
  end

  assign value      = value_q;
  assign bytes_used = bytes_used_q;
  assign trap       = trap_q;

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed bench for the LEB128 decoder with hand-computed expectations.
module tb_leb128_decoder;

  logic        clk;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        is_signed;
  logic        is_64;
  logic [63:0] value;
  logic        value_valid;
  logic        value_ready;
  logic [3:0]  bytes_used;
  logic [3:0]  trap;
  logic        trap_clear;

  int n_cmp = 0;
  int n_bad = 0;

  leb128_decoder #(.TRAP_CODE(4'd2)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .is_signed  (is_signed),
    .is_64      (is_64),
    .value      (value),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .bytes_used (bytes_used),
    .trap       (trap),
    .trap_clear (trap_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one byte for a single cycle; inputs change 1 time unit after the edge.
  task automatic send(input logic [7:0] b, input logic s, input logic w);
    byte_in    = b;
    is_signed  = s;
    is_64      = w;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    value_ready = 1'b1;
    byte_valid  = 1'b1;
    byte_in     = 8'h7f;
    step();
    value_ready = 1'b0;
    byte_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; byte_in = 8'h0; byte_valid = 1'b0; is_signed = 1'b0; is_64 = 1'b0;
    value_ready = 1'b0; trap_clear = 1'b0;
    #12;
    chk("rst_value", value, 64'h0);
    chk("rst_valid", 64'(value_valid), 64'h0);
    chk("rst_bytes", 64'(bytes_used), 64'h0);
    chk("rst_trap", 64'(trap), 64'h0);
    @(posedge clk); #1; reset = 1'b1;
    step();
    chk("idle_ready", 64'(byte_ready), 64'h1);

    // Unsigned 32-bit E5 8E 26 -> 0x98765
    send(8'he5, 1'b0, 1'b0);
    send(8'h8e, 1'b0, 1'b0);
    chk("u32_mid_valid", 64'(value_valid), 64'h0);
    send(8'h26, 1'b0, 1'b0);
    chk("u32_valid", 64'(value_valid), 64'h1);
    chk("u32_value", value, 64'h0000_0000_0009_8765);
    chk("u32_bytes", 64'(bytes_used), 64'd3);
    // Hold without consuming for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_value", value, 64'h0000_0000_0009_8765);
      chk("hold_bytes", 64'(bytes_used), 64'd3);
      chk("hold_valid", 64'(value_valid), 64'h1);
      chk("hold_ready", 64'(byte_ready), 64'h0);
    end
    // The byte offered on the consume cycle must not be taken
    consume();
    chk("post_consume_valid", 64'(value_valid), 64'h0);
    chk("post_consume_ready", 64'(byte_ready), 64'h1);

    // Signed 32-bit C0 BB 78 -> -123456
    send(8'hc0, 1'b1, 1'b0);
    send(8'hbb, 1'b1, 1'b0);
    send(8'h78, 1'b1, 1'b0);
    chk("s32_value", value, 64'hFFFF_FFFF_FFFE_1DC0);
    chk("s32_bytes", 64'(bytes_used), 64'd3);
    consume();

    send(8'h7f, 1'b1, 1'b0);
    chk("s7f_value", value, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("s7f_bytes", 64'(bytes_used), 64'd1);
    consume();
    send(8'h7f, 1'b0, 1'b0);
    chk("u7f_value", value, 64'h7F);
    consume();

    // Mode is latched on the first byte: 80 (unsigned) then 7F (is_signed=1 ignored)
    send(8'h80, 1'b0, 1'b0);
    send(8'h7f, 1'b1, 1'b1);
    chk("mode_latch_value", value, 64'h3F80);
    chk("mode_latch_bytes", 64'(bytes_used), 64'd2);
    consume();

    // Unsigned 32-bit max value in 5 bytes
    for (int i = 0; i < 4; i++) send(8'hff, 1'b0, 1'b0);
    send(8'h0f, 1'b0, 1'b0);
    chk("u32max_value", value, 64'h0000_0000_FFFF_FFFF);
    chk("u32max_bytes", 64'(bytes_used), 64'd5);
    chk("u32max_trap", 64'(trap), 64'h0);
    consume();

    // Signed 32-bit -1 in 5 bytes, last byte bits[6:3] all set
    for (int i = 0; i < 4; i++) send(8'hff, 1'b1, 1'b0);
    send(8'h7f, 1'b1, 1'b0);
    chk("s32_5b_value", value, 64'hFFFF_FFFF_FFFF_FFFF);
    consume();

    // Unsigned 32-bit overflow in byte 5 -> trap
    for (int i = 0; i < 4; i++) send(8'hff, 1'b0, 1'b0);
    send(8'h1f, 1'b0, 1'b0);
    chk("u32ovf_trap", 64'(trap), 64'd2);
    chk("u32ovf_ready", 64'(byte_ready), 64'h0);
    chk("u32ovf_valid", 64'(value_valid), 64'h0);
    step();
    chk("err_sticky", 64'(trap), 64'd2);
    trap_clear = 1'b1;
    step();
    trap_clear = 1'b0;
    chk("clr_trap", 64'(trap), 64'h0);
    chk("clr_ready", 64'(byte_ready), 64'h1);

    // Unsigned 64-bit: 10 continuation bytes -> trap on the 10th
    for (int i = 0; i < 9; i++) send(8'h80, 1'b0, 1'b1);
    chk("u64_9_trap", 64'(trap), 64'h0);
    chk("u64_9_valid", 64'(value_valid), 64'h0);
    send(8'h80, 1'b0, 1'b1);
    chk("u64_10_trap", 64'(trap), 64'd2);
    chk("u64_10_valid", 64'(value_valid), 64'h0);
    trap_clear = 1'b1;
    step();
    trap_clear = 1'b0;

    // Signed 64-bit -1 in 10 bytes
    for (int i = 0; i < 9; i++) send(8'hff, 1'b1, 1'b1);
    send(8'h7f, 1'b1, 1'b1);
    chk("s64_value", value, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("s64_bytes", 64'(bytes_used), 64'd10);
    consume();

    // Unsigned 64-bit 2^63 in 10 bytes
    for (int i = 0; i < 9; i++) send(8'h80, 1'b0, 1'b1);
    send(8'h01, 1'b0, 1'b1);
    chk("u64_top_value", value, 64'h8000_0000_0000_0000);
    consume();

    // Reset mid-value discards the partial result
    send(8'h80, 1'b0, 1'b0);
    send(8'h80, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    chk("midrst_value", value, 64'h0);
    chk("midrst_valid", 64'(value_valid), 64'h0);
    chk("midrst_bytes", 64'(bytes_used), 64'h0);
    chk("midrst_trap", 64'(trap), 64'h0);
    step();
    reset = 1'b1;
    send(8'h05, 1'b0, 1'b0);
    chk("after_rst_value", value, 64'h5);
    chk("after_rst_bytes", 64'(bytes_used), 64'd1);
    chk("after_rst_valid", 64'(value_valid), 64'h1);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/leb128_decoder.md
LEB128_DECODER -- requirements
Module: leb128_decoder

Interface
REQ-001 SHALL have parameter TRAP_CODE, default 4'd2: code driven on trap for a malformed or over-long LEB128 immediate.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port byte_in, input, 8: next immediate byte from the instruction fetch stage.
REQ-005 SHALL have port byte_valid, input, 1: byte_in is valid this cycle.
REQ-006 SHALL have port byte_ready, output, 1: decoder accepts byte_in this cycle.
REQ-007 SHALL have port is_signed, input, 1: varsN (1) or varuN (0); sampled with the first byte of a value.
REQ-008 SHALL have port is_64, input, 1: 64-bit (1) or 32-bit (0) immediate; sampled with the first byte.
REQ-009 SHALL have port value, output, 64: decoded immediate, extended to 64 bits.
REQ-010 SHALL have port value_valid, output, 1: value holds a complete decoded immediate.
REQ-011 SHALL have port value_ready, input, 1: the CPU consumes value this cycle.
REQ-012 SHALL have port bytes_used, output, 4: encoded length of value (1-10), valid alongside value_valid; used for PC advance.
REQ-013 SHALL have port trap, output, 4: 0 = no trap, TRAP_CODE = decode error; sticky.
REQ-014 SHALL have port trap_clear, input, 1: synchronous clear of trap, returning the block to ACCUM.

Function
REQ-015 SHALL implement states ACCUM, DONE and ERROR; a byte transfers when byte_valid and byte_ready are both high.
REQ-016 SHALL drive byte_ready high only in ACCUM.
REQ-017 SHALL, per transferred byte, OR byte_in[6:0] into the accumulator at bit offset 7*k, where k is the byte index starting at 0, and increment k.
REQ-018 SHALL, on a transferred byte with bit7=0, enter DONE and assert value_valid on the next cycle (latency 1 cycle after the final byte).
REQ-019 SHALL hold value, bytes_used and value_valid stable in DONE until value_ready is high; on that cycle it returns to ACCUM with k=0 and the accumulator cleared.
REQ-020 SHALL NOT accept a new byte in the same cycle value is consumed; the first byte of the next value is accepted no earlier than the following cycle.
REQ-021 SHALL, when signed and the final byte has bit6=1, fill bits above 7*(k+1) with 1s up to the selected width.
REQ-022 SHALL, for 32-bit results, sign-extend bit31 into [63:32] when signed and zero-extend when unsigned.
REQ-023 SHALL, for a 32-bit value, limit encoding to 5 bytes; in byte 5, unsigned requires bits[6:4]=0 and signed requires bits[6:3] all equal.
REQ-024 SHALL, for a 64-bit value, limit encoding to 10 bytes; in byte 10, unsigned requires bits[6:1]=0 and signed requires bits[6:0] all 0 or all 1.
REQ-025 SHALL enter ERROR and set trap=TRAP_CODE on the cycle after a violating byte; a violation is bit7=1 on the maximum-length byte, or a REQ-023/024 bit check failing.
REQ-026 SHALL, in ERROR, hold byte_ready=0 and value_valid=0 until trap_clear or reset.
REQ-027 SHALL ignore is_signed and is_64 on all bytes after the first.

Reset
REQ-028 SHALL, while reset is low, asynchronously force state=ACCUM, k=0, accumulator=0, value=0, value_valid=0, bytes_used=0 and trap=0.
REQ-029 SHALL discard any partially decoded value when reset is asserted mid-value.

Structure
REQ-030 SHALL take the state encoding, the trap code constants (shared with cpu) and the max-length constants 5 and 10 from the shared wasmachine package/header.
REQ-031 SHALL be a single module with no sub-modules; the final-byte check is a local function.

Verification
REQ-032 Unsigned 32-bit bytes E5 8E 26 -> value=0x00000000_00098765, bytes_used=3, value_valid 1 cycle after 26.
REQ-033 Signed 32-bit bytes C0 BB 78 -> value=0xFFFFFFFF_FFFE1DC0 (-123456); signed 7F -> all ones; unsigned 7F -> 0x7F.
REQ-034 Unsigned 32-bit FF FF FF FF 0F -> 0x00000000_FFFFFFFF; same with last byte 1F -> trap=TRAP_CODE, byte_ready=0; trap_clear -> trap=0, byte_ready=1.
REQ-035 Unsigned 64-bit with 10 bytes of 80, all continuation set -> trap on the 10th byte; no value_valid pulse.
REQ-036 Hold value_ready low for 3 cycles after DONE -> value, bytes_used and value_valid stable, byte_ready=0 throughout.
REQ-037 Assert reset after bytes 80 80 -> all outputs 0; then unsigned 05 -> value=5, bytes_used=1.
